memory_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 256-bit line memory (10-cycle `DataMemory`). It sits between the instruction-cache and data-cache miss paths (master 0 and master 1) and the single memory port. It grants one requester at a time, captures and holds the command stable for the whole memory access, and issues a one-cycle enable. It then returns the memory acknowledge and read line to the granted master.

---
 rtl/memory_arbiter.sv | 159 +++++++++++++++
 tb/tb_memory_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-master arbiter and sequencer for a shared 10-cycle line memory.
// Define ARB_FIXED_PRIORITY_EN for fixed priority (master 0 wins ties); default is round-robin.
module memory_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clock_i,
  input  logic              flush_i,

  input  logic              m0_req_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [LINE_W-1:0] m0_data_o,

  input  logic              m1_req_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [LINE_W-1:0] m1_data_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,

  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;

  logic any_req;
  logic win1;  // master 1 is the winner of the current IDLE decision

  assign any_req = m0_req_i | m1_req_i;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    win1 = m1_req_i & ~m0_req_i;
  end
`else
  logic last_q, last_d;

  // On a tie the master that did not win last time is served.
  always_comb begin
    if (m0_req_i && m1_req_i) begin
      win1 = ~last_q;
    end else begin
      win1 = m1_req_i;
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == StIdle && any_req) begin
      last_d = win1;
    end
  end

  always_ff @(posedge clock_i or posedge flush_i) begin
    if (flush_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StIssue;
          // Command is captured once here and held for the whole access.
          if (win1) begin
            grant_d     = 2'b10;
            mem_write_d = m1_write_i;
            mem_addr_d  = m1_addr_i;
            mem_data_d  = m1_data_i;
          end else begin
            grant_d     = 2'b01;
            mem_write_d = m0_write_i;
            mem_addr_d  = m0_addr_i;
            mem_data_d  = m0_data_i;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (mem_ack_i) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge flush_i) begin
    if (flush_i) begin
      state_q     <= StIdle;
      grant_q     <= 2'b00;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  logic done;
  assign done = (state_q == StDone);

  assign mem_enable_o = (state_q == StIssue);
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign grant_o      = grant_q;

  assign m0_ack_o = done & grant_q[0];
  assign m1_ack_o = done & grant_q[1];

  // Read line is forwarded only during a read ack; writes return zero.
  assign m0_data_o = (m0_ack_o && !mem_write_q) ? mem_data_i : '0;
  assign m1_data_o = (m1_ack_o && !mem_write_q) ? mem_data_i : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter with a 10-cycle line memory model and a
// transaction-level scheduler/scoreboard for randomized traffic.
module tb_memory_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          flush;
  logic          req   [2];
  logic          wr    [2];
  logic [AW-1:0] addr  [2];
  logic [LW-1:0] wdata [2];
  logic [1:0]    ack;
  logic [LW-1:0] rdata [2];
  logic          mem_en, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    grant;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clock_i      (clk),
    .flush_i      (flush),
    .m0_req_i     (req[0]),
    .m0_write_i   (wr[0]),
    .m0_addr_i    (addr[0]),
    .m0_data_i    (wdata[0]),
    .m0_ack_o     (ack[0]),
    .m0_data_o    (rdata[0]),
    .m1_req_i     (req[1]),
    .m1_write_i   (wr[1]),
    .m1_addr_i    (addr[1]),
    .m1_data_i    (wdata[1]),
    .m1_ack_o     (ack[1]),
    .m1_data_o    (rdata[1]),
    .mem_enable_o (mem_en),
    .mem_write_o  (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_data_i   (mem_rdata),
    .grant_o      (grant)
  );

  // Line memory: counts 0..9 after the enable, ack is combinational on the last count.
  logic [LW-1:0] mem_arr [32];
  logic          mem_busy;
  int            mem_cnt;
  logic          pre_en;
  logic [4:0]    pre_idx;
  logic [LW-1:0] pre_val;

  assign mem_ack = mem_busy && (mem_cnt == 9);

  always @(posedge clk or posedge flush) begin
    if (flush) begin
      mem_busy  <= 1'b0;
      mem_cnt   <= 0;
      mem_rdata <= '0;
    end else begin
      if (pre_en) mem_arr[pre_idx] <= pre_val;
      if (mem_busy) begin
        if (mem_cnt == 9) begin
          mem_busy <= 1'b0;
          if (mem_we) mem_arr[mem_addr[9:5]] <= mem_wdata;
          else        mem_rdata <= mem_arr[mem_addr[9:5]];
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end else if (mem_en) begin
        mem_busy <= 1'b1;
        mem_cnt  <= 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [4:0] idx, input logic [LW-1:0] val);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    tick();
    pre_en  = 1'b0;
  endtask

  task automatic do_reset();
    req[0] = 1'b0;
    req[1] = 1'b0;
    flush  = 1'b1;
    tick();
    tick();
    flush  = 1'b0;
    tick();
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Waits (bounded) for master m's ack; cyc = -1 if none within budget.
  task automatic wait_ack(input int m, input int budget, output int cyc,
                          output logic [LW-1:0] d);
    cyc = -1;
    d   = '0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (ack[m]) begin
        cyc = i;
        d   = rdata[m];
        return;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if ({mem_en, mem_we, grant, ack} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {mem_en, mem_we, grant, ack});
    else n_pass++;
    n_checks++;
    if (mem_addr !== '0) $display("FAIL reset_addr: got %h expected 0", mem_addr);
    else n_pass++;
    n_checks++;
    if (mem_wdata !== '0) $display("FAIL reset_wdata: got %h expected 0", mem_wdata);
    else n_pass++;
    n_checks++;
    if ((rdata[0] | rdata[1]) !== '0) $display("FAIL reset_rdata: got %h expected 0",
                                               rdata[0] | rdata[1]);
    else n_pass++;
    flush = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    preload(5'd2, a5);
    wr[0] = 1'b0; addr[0] = 32'h40; wdata[0] = '0; req[0] = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      n_checks++;
      if (mem_en !== (c == 1)) $display("FAIL sr_enable c=%0d: got %b expected %b",
                                        c, mem_en, (c == 1));
      else n_pass++;
      n_checks++;
      if (ack[0] !== (c == 12)) $display("FAIL sr_ack c=%0d: got %b expected %b",
                                         c, ack[0], (c == 12));
      else n_pass++;
      n_checks++;
      if (grant !== ((c <= 12) ? 2'b01 : 2'b00))
        $display("FAIL sr_grant c=%0d: got %b expected %b", c, grant,
                 (c <= 12) ? 2'b01 : 2'b00);
      else n_pass++;
      if (c == 12) begin
        n_checks++;
        if (rdata[0] !== a5) $display("FAIL sr_data: got %h expected %h", rdata[0], a5);
        else n_pass++;
        req[0] = 1'b0;
      end
    end
  endtask

  task automatic test_write_read();
    int cyc;
    logic [LW-1:0] d;
    wr[1] = 1'b1; addr[1] = 32'h80; wdata[1] = 256'h1234; req[1] = 1'b1;
    wait_ack(1, 30, cyc, d);
    n_checks++;
    if (cyc !== 12) $display("FAIL wr_latency: got %0d expected 12", cyc);
    else n_pass++;
    n_checks++;
    if (d !== '0) $display("FAIL wr_data: got %h expected 0", d);
    else n_pass++;
    wr[1] = 1'b0; wdata[1] = '0;
    wait_ack(1, 30, cyc, d);
    req[1] = 1'b0;
    n_checks++;
    if (cyc !== 13) $display("FAIL rd_after_wr_latency: got %0d expected 13", cyc);
    else n_pass++;
    n_checks++;
    if (d !== 256'h1234) $display("FAIL rd_after_wr_data: got %h expected 1234", d);
    else n_pass++;
  endtask

  task automatic test_tie();
    int a0 [2];
    int a1, k0, e0b, e1;
`ifdef ARB_FIXED_PRIORITY_EN
    e0b = 25; e1 = 38;
`else
    e0b = 38; e1 = 25;
`endif
    do_reset();
    a0[0] = -1; a0[1] = -1; a1 = -1; k0 = 0;
    wr[0] = 1'b0; addr[0] = 32'h40;
    wr[1] = 1'b0; addr[1] = 32'h80;
    req[0] = 1'b1; req[1] = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (ack[0]) begin
        if (k0 < 2) a0[k0] = c;
        k0++;
        if (k0 >= 2) req[0] = 1'b0;  // m0 re-requests once, creating a second tie
      end
      if (ack[1]) begin
        a1 = c;
        req[1] = 1'b0;
      end
      if (k0 >= 2 && a1 >= 0) break;
    end
    req[0] = 1'b0; req[1] = 1'b0;
    n_checks++;
    if (a0[0] !== 12) $display("FAIL tie_m0_first: got %0d expected 12", a0[0]);
    else n_pass++;
    n_checks++;
    if (a1 !== e1) $display("FAIL tie_m1: got %0d expected %0d", a1, e1);
    else n_pass++;
    n_checks++;
    if (a0[1] !== e0b) $display("FAIL tie_m0_repeat: got %0d expected %0d", a0[1], e0b);
    else n_pass++;
    tick();
  endtask

  task automatic test_addr_stability();
    logic [LW-1:0] d1, d2, k;
    d1 = rand_line(); d2 = rand_line(); k = rand_line();
    preload(5'd6, '0);
    preload(5'd8, k);
    wr[0] = 1'b1; addr[0] = 32'hC0; wdata[0] = d1; req[0] = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 5) begin
        addr[0]  = 32'h100;
        wdata[0] = d2;
      end
      if (c >= 2 && c <= 12) begin
        n_checks++;
        if ({mem_we, mem_addr} !== {1'b1, 32'hC0})
          $display("FAIL stab_addr c=%0d: got %b/%h expected 1/000000c0", c, mem_we, mem_addr);
        else n_pass++;
        n_checks++;
        if (mem_wdata !== d1) $display("FAIL stab_data c=%0d: got %h expected %h",
                                       c, mem_wdata, d1);
        else n_pass++;
      end
      if (c == 12) req[0] = 1'b0;
    end
    n_checks++;
    if (mem_arr[6] !== d1) $display("FAIL stab_mem_line: got %h expected %h", mem_arr[6], d1);
    else n_pass++;
    n_checks++;
    if (mem_arr[8] !== k) $display("FAIL stab_other_line: got %h expected %h", mem_arr[8], k);
    else n_pass++;
  endtask

  task automatic test_flush();
    int cyc;
    logic [LW-1:0] d;
    wr[0] = 1'b0; addr[0] = 32'h40; wdata[0] = '0; req[0] = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    flush = 1'b1;
    #1;
    n_checks++;
    if ({mem_en, mem_we, grant, ack} !== 6'b0)
      $display("FAIL flush_ctrl: got %b expected 000000", {mem_en, mem_we, grant, ack});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata} !== '0)
      $display("FAIL flush_cmd: got %h/%h expected 0", mem_addr, mem_wdata);
    else n_pass++;
    req[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (ack !== 2'b00) $display("FAIL flush_no_ack: got %b expected 00", ack);
      else n_pass++;
    end
    flush = 1'b0;
    tick();
    n_checks++;
    if (ack !== 2'b00) $display("FAIL flush_release_no_ack: got %b expected 00", ack);
    else n_pass++;
    req[0] = 1'b1;
    wait_ack(0, 30, cyc, d);
    req[0] = 1'b0;
    n_checks++;
    if (cyc !== 12) $display("FAIL flush_rereq_latency: got %0d expected 12", cyc);
    else n_pass++;
    n_checks++;
    if (d !== {32{8'hA5}}) $display("FAIL flush_rereq_data: got %h expected a5..a5", d);
    else n_pass++;
  endtask

  task automatic test_late_request();
    int a0, a1;
    logic [LW-1:0] p, d1;
    p = rand_line();
    preload(5'd4, p);
    a0 = -1; a1 = -1; d1 = '0;
    wr[0] = 1'b0; addr[0] = 32'h40;
    wr[1] = 1'b0; addr[1] = 32'h80;
    req[0] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 5) req[1] = 1'b1;
      if (c == 14) begin
        n_checks++;
        if (grant !== 2'b10) $display("FAIL late_grant: got %b expected 10", grant);
        else n_pass++;
      end
      if (ack[0]) begin a0 = c; req[0] = 1'b0; end
      if (ack[1]) begin a1 = c; d1 = rdata[1]; req[1] = 1'b0; end
      if (a1 >= 0) break;
    end
    req[0] = 1'b0; req[1] = 1'b0;
    n_checks++;
    if (a0 !== 12) $display("FAIL late_m0_ack: got %0d expected 12", a0);
    else n_pass++;
    n_checks++;
    if (a1 !== 25) $display("FAIL late_m1_ack: got %0d expected 25", a1);
    else n_pass++;
    n_checks++;
    if (d1 !== p) $display("FAIL late_m1_data: got %h expected %h", d1, p);
    else n_pass++;
    tick();
  endtask

  // Transaction-level model: one access at a time, 12 cycles from sample to ack,
  // next sample one cycle after the ack, tie winner chosen by the arbitration rule.
  task automatic test_random();
    logic [LW-1:0] ref_mem [8];
    logic [LW-1:0] exp_d;
    int  exp_ack [2];
    bit  sched   [2];
    int  idx     [2];
    int  free_at, last_w, w, got, expc;
    bit  p0, p1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = rand_line();
      preload(5'(i), ref_mem[i]);
    end
    free_at = 0; last_w = 1;
    sched[0] = 0; sched[1] = 0; exp_ack[0] = -1; exp_ack[1] = -1;
    for (int c = 0; c < 1600; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (ack[m] || (sched[m] && c >= exp_ack[m])) begin
          got  = ack[m] ? c : -1;
          expc = sched[m] ? exp_ack[m] : -1;
          n_checks++;
          if (got !== expc) $display("FAIL rnd_ack_cycle m%0d: got %0d expected %0d",
                                     m, got, expc);
          else n_pass++;
          if (ack[m] && sched[m]) begin
            exp_d = wr[m] ? '0 : ref_mem[idx[m]];
            n_checks++;
            if (rdata[m] !== exp_d) $display("FAIL rnd_data m%0d c=%0d: got %h expected %h",
                                             m, c, rdata[m], exp_d);
            else n_pass++;
            if (wr[m]) ref_mem[idx[m]] = wdata[m];
          end
          sched[m] = 0;
          req[m]   = 1'b0;
        end
        if (!req[m] && c < 1500 && $urandom_range(0, 3) == 0) begin
          idx[m]   = $urandom_range(0, 7);
          wr[m]    = 1'($urandom_range(0, 1));
          addr[m]  = 32'(idx[m] * 32 + $urandom_range(0, 31));
          wdata[m] = rand_line();
          req[m]   = 1'b1;
        end
      end
      if (c >= free_at) begin
        p0 = req[0] && !sched[0];
        p1 = req[1] && !sched[1];
        if (p0 || p1) begin
`ifdef ARB_FIXED_PRIORITY_EN
          w = p0 ? 0 : 1;
`else
          w = (p0 && p1) ? ((last_w == 0) ? 1 : 0) : (p1 ? 1 : 0);
`endif
          sched[w]   = 1;
          exp_ack[w] = c + 12;
          free_at    = c + 13;
          last_w     = w;
        end
      end
      tick();
    end
    req[0] = 1'b0; req[1] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    flush = 1'b1;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; wr[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
    end
    test_reset();
    test_single_read();
    test_write_read();
    test_tie();
    test_addr_stability();
    test_flush();
    test_late_request();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
